// File: rtl/sad_serial_ctrl.sv
// sad_serial_ctrl: bit-serial block SAD controller sharing one full adder for subtract, swap and accumulate.
// Define SAD_ZERO_SKIP_EN to bypass accumulation of pairs whose difference is zero.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module sad_serial_ctrl #(
  parameter int PIX_W = 8,
  parameter int BLK_N = 16,
  parameter int ACC_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_a,
  input  logic [PIX_W-1:0] i_pix_b,
  output logic             o_pix_ready,
  output logic             o_busy,
  output logic [ACC_W-1:0] o_sad,
  output logic             o_sad_valid
);
  localparam int BW = $clog2(PIX_W + ACC_W + 1);
  localparam int CW = $clog2(BLK_N);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_SWAP, S_ACC, S_DONE} state_t;
  state_t r_state, w_next, w_pair_end;
  logic [PIX_W-1:0] r_a, r_b, r_diff, w_diff_d;
  logic [ACC_W-1:0] r_acc, r_sad, w_acc_d;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic r_carry, w_fa_a, w_fa_b, w_sum, w_cout, w_skip;
  logic w_last_pix, w_last_acc, w_last_pair;
  assign w_fa_a = (r_state == S_ACC) ? r_acc[0] : (r_state == S_SWAP) ? r_b[0] : r_a[0];
  assign w_fa_b = (r_state == S_ACC) ? r_diff[0] : (r_state == S_SWAP) ? ~r_a[0] : ~r_b[0];
  full_adder u_fa (.i_a(w_fa_a), .i_b(w_fa_b), .i_cin(r_carry), .o_sum(w_sum), .o_cout(w_cout));
  assign w_diff_d    = {w_sum, r_diff[PIX_W-1:1]};
  assign w_acc_d     = {w_sum, r_acc[ACC_W-1:1]};
  assign w_last_pix  = r_bit == BW'(PIX_W - 1);
  assign w_last_acc  = r_bit == BW'(ACC_W - 1);
  assign w_last_pair = r_cnt == CW'(BLK_N - 1);
  assign w_pair_end  = w_last_pair ? S_DONE : S_LOAD;
`ifdef SAD_ZERO_SKIP_EN
  assign w_skip = w_diff_d == '0;
`else
  assign w_skip = 1'b0;
`endif
  assign o_pix_ready = r_state == S_LOAD;
  assign o_busy      = r_state != S_IDLE;
  assign o_sad_valid = r_state == S_DONE;
  assign o_sad       = r_sad;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = i_start ? S_LOAD : S_IDLE;
      S_LOAD: w_next = i_pix_valid ? S_SUB : S_LOAD;
      S_SUB:  if (w_last_pix) w_next = !w_cout ? S_SWAP : w_skip ? w_pair_end : S_ACC;
      S_SWAP: if (w_last_pix) w_next = S_ACC;
      S_ACC:  if (w_last_acc) w_next = w_pair_end;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_acc   <= '0;
      r_sad   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_bit   <= (w_next != r_state) ? '0 : r_bit + 1'b1;
      r_carry <= w_cout;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_LOAD: if (i_pix_valid) begin
          r_a     <= i_pix_a;
          r_b     <= i_pix_b;
          r_carry <= 1'b1;
        end
        S_SUB, S_SWAP: begin
          // operands rotate so SWAP sees them intact after SUB
          r_a    <= {r_a[0], r_a[PIX_W-1:1]};
          r_b    <= {r_b[0], r_b[PIX_W-1:1]};
          r_diff <= w_diff_d;
          if (w_last_pix) r_carry <= (r_state == S_SUB) && !w_cout;
        end
        S_ACC: begin
          r_acc  <= w_acc_d;
          r_diff <= {1'b0, r_diff[PIX_W-1:1]};
        end
        default: ;
      endcase
      if (w_next == S_LOAD && (r_state == S_ACC || r_state == S_SUB)) r_cnt <= r_cnt + 1'b1;
      if (w_next == S_DONE) r_sad <= (r_state == S_ACC) ? w_acc_d : r_acc;
    end
  end
endmodule

// File: tb/tb_sad_serial_ctrl.sv
// tb_sad_serial_ctrl: directed blocks with a scoreboard for SAD results and pair-to-pair cycle spacing.
module tb_sad_serial_ctrl;
  logic clk = 0, rst = 1, start = 0, pv = 0;
  logic [7:0] pa = 0, pb = 0;
  logic o_pix_ready, o_busy, o_sad_valid;
  logic [11:0] o_sad;
  int n_tests = 0, n_fail = 0, cyc = 0, hs_cyc = 0;
  bit pending = 0, chk_hold = 0;
  int sp_q[$];
  logic [11:0] sad_q[$];
  logic [11:0] last_sad;
`ifdef SAD_ZERO_SKIP_EN
  localparam int ZSP = 9;
`else
  localparam int ZSP = 21;
`endif

  sad_serial_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pix_valid(pv),
    .i_pix_a(pa), .i_pix_b(pb), .o_pix_ready(o_pix_ready), .o_busy(o_busy),
    .o_sad(o_sad), .o_sad_valid(o_sad_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (pv && o_pix_ready) begin
      hs_cyc = cyc;
      pending = 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (pending && (o_pix_ready || o_sad_valid)) begin
      pending = 0;
      if (sp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pair_spacing: got %0d expected none queued", cyc - hs_cyc);
      end else check("pair_spacing", cyc - hs_cyc, sp_q.pop_front());
    end
    if (o_sad_valid) begin
      if (sad_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sad_valid: got unexpected pulse with sad %0d expected no pulse", o_sad);
      end else check("sad", o_sad, sad_q.pop_front());
      last_sad = o_sad;
      chk_hold = 1;
    end else if (chk_hold) begin
      check("sad_hold", o_sad, last_sad);
      chk_hold = 0;
    end
  end

  task automatic wait_ready();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_pix_ready) return;
    end
    n_tests++; n_fail++;
    $display("FAIL ready_timeout: got ready 0 expected ready 1 within 100 cycles");
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("start_to_ready", o_pix_ready, 1);
    check("start_busy", o_busy, 1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int gap, input int sp);
    sp_q.push_back(sp);
    wait_ready();
    if (gap > 0) begin
      pa = 8'hFF; pb = 8'h00;
      repeat (gap) @(negedge clk);
      check("stall_ready", o_pix_ready, 1);
    end
    #1 pv = 1; pa = a; pb = b;
    @(posedge clk); #1 pv = 0; pa = 8'hAA; pb = 8'h55;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!o_busy) begin
        check("idle_ready", o_pix_ready, 0);
        check("scoreboard_drained", sad_q.size(), 0);
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL idle_timeout: got busy 1 expected busy 0 within 200 cycles");
  endtask

  task automatic run_block(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                           input logic [7:0] b1, input int gap, input int sp0, input int sp1,
                           input logic [11:0] exp, input bit poke);
    sad_q.push_back(exp);
    do_start();
    for (int i = 0; i < 16; i++) begin
      send((i % 2) ? a1 : a0, (i % 2) ? b1 : b0, gap, (i % 2) ? sp1 : sp0);
      if (poke && i == 0) begin
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
      end
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sad"}, o_sad, 0);
    check({tag, "_sad_valid"}, o_sad_valid, 0);
    check({tag, "_pix_ready"}, o_pix_ready, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 0;
    run_block(37, 37, 37, 37, 0, ZSP, ZSP, 12'd0, 0);
    run_block(200, 50, 200, 50, 0, 21, 21, 12'd2400, 1);
    run_block(0, 255, 0, 255, 0, 29, 29, 12'd4080, 0);
    run_block(10, 3, 3, 10, 5, 21, 29, 12'd112, 0);
    do_start();
    for (int i = 0; i < 7; i++) send(200, 50, 0, 21);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    pending = 0;
    sp_q.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1 rst = 0;
    run_block(1, 0, 1, 0, 0, 21, 21, 12'd16, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sad_serial_ctrl.md
# sad_serial_ctrl

Bit-serial sum-of-absolute-difference engine controller that time-shares a single `full_adder` cell for subtraction, conditional reversal and accumulation. It accepts a block of `BLK_N` pixel pairs over a valid/ready handshake, sequences the shared adder LSB-first, and presents the block SAD with a one-cycle valid pulse. It sits between the pixel fetch logic and the SAD comparison/decision stage, and is the area-minimal alternative to the parallel compressor tree.

## Interface
- `PIX_W`, 8, pixel width in bits
- `BLK_N`, 16, pixel pairs per block (≥2)
- `ACC_W`, 12, accumulator width; must be ≥ `PIX_W` + clog2(`BLK_N`)

- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_start`  in  1  begin a block; sampled only in IDLE
- `i_pix_valid`  in  1  pixel pair present
- `i_pix_a`  in  PIX_W  current-block pixel, unsigned
- `i_pix_b`  in  PIX_W  reference-block pixel, unsigned
- `o_pix_ready`  out  1  controller accepts a pair this cycle
- `o_busy`  out  1  high in every state except IDLE
- `o_sad`  out  ACC_W  last completed block SAD, held until the next DONE
- `o_sad_valid`  out  1  one-cycle pulse when `o_sad` updates

## Operation
- Exactly one `full_adder` instance. Operand A, operand B and carry-in are muxed per state; the carry register feeds carry-in, and the sum is shifted into the destination register MSB-first so the result ends LSB-aligned.
- States:
  - IDLE: `i_start`=1 → clear accumulator and pair counter → LOAD.
  - LOAD: `o_pix_ready`=1. Handshake (`i_pix_valid`&`o_pix_ready`) captures a, b → SUB, carry reg=1.
  - SUB: `PIX_W` cycles computing a + ~b + 1 into diff. Final carry-out: 1 means a≥b → ACC (carry reg=0); 0 means a<b → SWAP (carry reg=1).
  - SWAP: `PIX_W` cycles computing b + ~a + 1 into diff → ACC (carry reg=0).
  - ACC: `ACC_W` cycles computing acc + zero-extended diff. Then if counter=`BLK_N`-1 → DONE, else counter+1 → LOAD.
  - DONE: 1 cycle. `o_sad`←acc, `o_sad_valid`=1 → IDLE.
- Arithmetic: diff is exact `PIX_W`-bit |a−b|. The accumulator never overflows given the `ACC_W` constraint, and no saturation is applied. The final carry-out in ACC is discarded.
- `i_start` is ignored outside IDLE. Pixel inputs are ignored outside the LOAD handshake.
- Reset at any time: state IDLE; accumulator, counter, carry, diff and `o_sad` cleared; `o_sad_valid`=0, `o_pix_ready`=0, `o_busy`=0. A partial block is discarded.

## Timing
- Reset values: `o_sad`=0, `o_sad_valid`=0, `o_pix_ready`=0, `o_busy`=0.
- From `i_start` sampled to the first `o_pix_ready`: 1 cycle.
- Per pair, measured from the handshake cycle to the next LOAD cycle:
  - `PIX_W`+`ACC_W`+1 cycles when a≥b.
  - 2·`PIX_W`+`ACC_W`+1 cycles when a<b.
  - With defaults: 21 or 29 cycles.
- `o_sad_valid` is asserted in the cycle after the last ACC cycle. `o_sad` is valid in that same cycle and stays stable afterwards.
- `o_pix_ready` is a registered state decode, not combinational from `i_pix_valid`.
- `o_busy` falls in the cycle after DONE. A new `i_start` is accepted from that cycle onward.

## Configuration
- `SAD_ZERO_SKIP_EN` defined: when SUB finishes with diff=0, ACC is skipped. The controller goes directly to LOAD, or to DONE for the last pair, and the pair costs `PIX_W`+1 cycles.
- Not defined: every pair passes through ACC, and the cycle count depends only on the sign of a−b.
- `o_sad` values are identical in both builds.

## Test plan
- Reset then `i_start`; 16 pairs a=b=37 → `o_sad`=0, one `o_sad_valid` pulse. Without the macro each pair takes 21 cycles; with `SAD_ZERO_SKIP_EN` each pair takes 9 cycles.
- 16 pairs a=200, b=50 → `o_sad`=2400. `o_pix_ready` re-asserts exactly 21 cycles after each handshake.
- 16 pairs a=0, b=255 → `o_sad`=4080, with SWAP taken each pair (29-cycle spacing). No overflow.
- Alternating pairs (10,3) and (3,10), with `i_pix_valid` deasserted for 5 cycles before each pair → `o_sad`=112; the controller stalls in LOAD with no state change.
- Assert `i_rst` during ACC of pair 7, then start a fresh block of 16 pairs (1,0) → all outputs are 0 during reset, and the new `o_sad`=16 with no residue from the aborted block.
- Pulse `i_start` while `o_busy`=1 → ignored; the pair count and the result are unchanged.
